// File: rtl/sprite_blitter.sv
// sprite_blitter
// Writer side of the VGA framebuffer port. Queues sprite draw commands in a
// small FIFO, scans each sprite row-major out of an external 2-bit sprite ROM
// and emits at most one framebuffer write per cycle. Everything except the
// FIFO input side freezes while the framebuffer swap window is open.
//
// Ports
//   clk_33m        system clock
//   rst            asynchronous reset, active-high
//   cmd_valid/cmd_ready, cmd_x, cmd_y, cmd_sprite, cmd_flip
//                  draw command handshake (transfer on valid && ready)
//   rst_screen_33m framebuffer swap window; the blitter stalls while high
//   rom_en, rom_addr  ROM read request {sprite, row, col}
//   rom_data       ROM pixel, valid one cycle after the request; 0 = transparent
//   write_x, write_y, write_palette  framebuffer write (palette 0 = no write)
//   busy           FIFO non-empty or a sprite still in flight
module sprite_blitter #(
    parameter int COOR_WIDTH      = 12,
    parameter int FRAME_W         = 1280,
    parameter int FRAME_H         = 300,
    parameter int SPRITE_W        = 32,
    parameter int SPRITE_H        = 32,
    parameter int SPRITE_ID_WIDTH = 4,
    parameter int ROM_ADDR_WIDTH  = 14,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                       clk_33m,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [COOR_WIDTH-1:0]      cmd_x,
    input  logic [COOR_WIDTH-1:0]      cmd_y,
    input  logic [SPRITE_ID_WIDTH-1:0] cmd_sprite,
    input  logic                       cmd_flip,
    input  logic                       rst_screen_33m,
    output logic                       rom_en,
    output logic [ROM_ADDR_WIDTH-1:0]  rom_addr,
    input  logic [1:0]                 rom_data,
    output logic [COOR_WIDTH-1:0]      write_x,
    output logic [COOR_WIDTH-1:0]      write_y,
    output logic [1:0]                 write_palette,
    output logic                       busy
);

    localparam int COL_W = $clog2(SPRITE_W);
    localparam int ROW_W = $clog2(SPRITE_H);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CMD_W = 2 * COOR_WIDTH + SPRITE_ID_WIDTH + 1;
    localparam int SUM_W = COOR_WIDTH + 1;

    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_MAX  = '1;
    localparam logic [ROW_W-1:0] ROW_MAX  = '1;
    localparam logic [SUM_W-1:0] X_LIMIT  = SUM_W'(FRAME_W);
    localparam logic [SUM_W-1:0] Y_LIMIT  = SUM_W'(FRAME_H);

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DRAIN} state_t;

    logic stall;
    assign stall = rst_screen_33m;

    // ---------------- command FIFO ----------------
    logic [CMD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg, count_next;
    logic             empty_reg, ready_reg;
    logic             push, pop;

    state_t state_reg, state_next;

    assign pop       = (state_reg == IDLE) && !empty_reg && !stall;
    // A pop frees a slot this cycle, so a full FIFO can still take a command.
    assign cmd_ready = ready_reg || pop;
    assign push      = cmd_valid && cmd_ready;

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + CNT_ONE;
        else if (pop && !push)
            count_next = count_reg - CNT_ONE;
    end

    always_ff @(posedge clk_33m) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {cmd_x, cmd_y, cmd_sprite, cmd_flip};
    end

    always_ff @(posedge clk_33m or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            empty_reg  <= 1'b1;
            ready_reg  <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            count_reg <= count_next;
            empty_reg <= (count_next == '0);
            ready_reg <= (count_next != CNT_FULL);
        end
    end

    // ---------------- scan FSM ----------------
    logic [COOR_WIDTH-1:0]      x_reg, y_reg;
    logic [SPRITE_ID_WIDTH-1:0] sprite_reg;
    logic                       flip_reg;
    logic [ROW_W-1:0]           row_reg;
    logic [COL_W-1:0]           col_reg;
    logic                       drain_reg;
    logic                       last_px, issue;

    assign last_px = (row_reg == ROW_MAX) && (col_reg == COL_MAX);
    assign issue   = (state_reg == DRAW) && !stall;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pop) state_next = LOAD;
            LOAD:    if (!stall) state_next = DRAW;
            DRAW:    if (!stall && last_px) state_next = DRAIN;
            DRAIN:   if (!stall && drain_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_33m or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            x_reg      <= '0;
            y_reg      <= '0;
            sprite_reg <= '0;
            flip_reg   <= 1'b0;
            row_reg    <= '0;
            col_reg    <= '0;
            drain_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (pop)
                {x_reg, y_reg, sprite_reg, flip_reg} <= fifo_mem[rd_ptr_reg];
            if (!stall) begin
                case (state_reg)
                    LOAD: begin
                        row_reg   <= '0;
                        col_reg   <= '0;
                        drain_reg <= 1'b0;
                    end
                    DRAW: begin
                        col_reg <= col_reg + COL_ONE;
                        if (col_reg == COL_MAX)
                            row_reg <= row_reg + ROW_ONE;
                    end
                    DRAIN:   drain_reg <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Sprite width is a power of two, so SPRITE_W-1-col is just ~col.
    logic [COL_W-1:0] rom_col;
    assign rom_col  = flip_reg ? ~col_reg : col_reg;
    assign rom_en   = issue;
    assign rom_addr = {sprite_reg, row_reg, rom_col};

    // One extra bit catches carry-out so a wrapped coordinate is clipped.
    logic [SUM_W-1:0] x_sum, y_sum;
    assign x_sum = {1'b0, x_reg} + {{(SUM_W - COL_W){1'b0}}, col_reg};
    assign y_sum = {1'b0, y_reg} + {{(SUM_W - ROW_W){1'b0}}, row_reg};

    // ---------------- pixel pipeline ----------------
    // Stage 1 lines up with the ROM access; the output stage with rom_data.
    logic                  s1_valid_reg, s1_clip_reg;
    logic [COOR_WIDTH-1:0] s1_x_reg, s1_y_reg;

    always_ff @(posedge clk_33m or posedge rst) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_clip_reg   <= 1'b0;
            s1_x_reg      <= '0;
            s1_y_reg      <= '0;
            write_x       <= '0;
            write_y       <= '0;
            write_palette <= '0;
        end else if (!stall) begin
            s1_valid_reg <= issue;
            s1_clip_reg  <= (x_sum >= X_LIMIT) || (y_sum >= Y_LIMIT);
            s1_x_reg     <= x_sum[COOR_WIDTH-1:0];
            s1_y_reg     <= y_sum[COOR_WIDTH-1:0];
            if (s1_valid_reg) begin
                write_x       <= s1_x_reg;
                write_y       <= s1_y_reg;
                write_palette <= s1_clip_reg ? 2'd0 : rom_data;
            end else begin
                write_palette <= 2'd0;
            end
        end
    end

    assign busy = !empty_reg || (state_reg != IDLE) || s1_valid_reg;

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: behavioural ROM, expected-write queue computed
// from whole-sprite arithmetic, directed scenarios plus randomized commands
// and swap-window stalls.
module tb_sprite_blitter;

    logic        clk_33m = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [11:0] cmd_x = '0;
    logic [11:0] cmd_y = '0;
    logic [3:0]  cmd_sprite = '0;
    logic        cmd_flip = 1'b0;
    logic        rst_screen_33m = 1'b0;
    logic        rom_en;
    logic [13:0] rom_addr;
    logic [1:0]  rom_data = '0;
    logic [11:0] write_x, write_y;
    logic [1:0]  write_palette;
    logic        busy;

    sprite_blitter dut (
        .clk_33m(clk_33m), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_sprite(cmd_sprite), .cmd_flip(cmd_flip),
        .rst_screen_33m(rst_screen_33m),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .write_x(write_x), .write_y(write_y), .write_palette(write_palette),
        .busy(busy)
    );

    always #5 clk_33m = ~clk_33m;

    logic [1:0] rom_mem [16384];
    always @(posedge clk_33m) if (rom_en) rom_data <= rom_mem[rom_addr];

    typedef struct packed {logic [11:0] x; logic [11:0] y; logic [1:0] pal;} wr_t;
    wr_t exp_q[$];
    wr_t last_exp = '0;
    int  checks = 0;
    int  failures = 0;
    int  writes_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every pixel of the sprite that lands on screen and is opaque, in scan order.
    function automatic int add_expected(input int x, input int y, input int id, input int flip);
        int n = 0;
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) begin
                int px = x + c;
                int py = y + r;
                int rc = flip ? 31 - c : c;
                logic [1:0] pal = rom_mem[id * 1024 + r * 32 + rc];
                if (pal != 0 && px < 1280 && py < 300) begin
                    exp_q.push_back('{x: 12'(px), y: 12'(py), pal: pal});
                    n++;
                end
            end
        end
        return n;
    endfunction

    // Outputs change only on edges that close a non-stalled cycle; count each once.
    initial begin
        bit upd;
        wr_t e;
        forever begin
            @(posedge clk_33m);
            upd = !rst && !rst_screen_33m;
            #1;
            if (upd && !rst && write_palette != 2'd0) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    check("extra_write", {6'b0, write_x, write_y, write_palette}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    last_exp = e;
                    check("write", {6'b0, write_x, write_y, write_palette}, {6'b0, e});
                end
            end
        end
    end

    task automatic push(input int x, input int y, input int id, input int flip);
        bit ok = 0;
        int n;
        @(negedge clk_33m);
        cmd_x = 12'(x); cmd_y = 12'(y); cmd_sprite = 4'(id); cmd_flip = flip[0];
        cmd_valid = 1'b1;
        for (int t = 0; t < 20000; t++) begin
            #1;
            if (cmd_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk_33m);
        end
        if (!ok) begin
            check("push_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk_33m);
        n = add_expected(x, y, id, flip);
        $display("cmd x=%0d y=%0d id=%0d flip=%0d expected_writes=%0d", x, y, id, flip, n);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit random_stall);
        bit done = 0;
        int stall_left = 0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk_33m);
            if (random_stall) begin
                if (stall_left == 0 && $urandom_range(0, 59) == 0)
                    stall_left = $urandom_range(1, 6);
                rst_screen_33m = (stall_left > 0);
                if (stall_left > 0) stall_left--;
            end
            #1;
            if (!busy && !rst_screen_33m) begin
                done = 1;
                break;
            end
        end
        rst_screen_33m = 1'b0;
        if (!done) check("idle_timeout", 32'd0, 32'd1);
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        int w0;
        for (int a = 0; a < 16384; a++) rom_mem[a] = 2'($urandom_range(0, 3));
        for (int a = 0; a < 1024; a++) begin
            rom_mem[1024 + a] = 2'd3;
            rom_mem[2048 + a] = 2'd0;
            rom_mem[3072 + a] = 2'd2;
        end
        rom_mem[2048] = 2'd1;

        // reset state
        repeat (3) @(posedge clk_33m);
        #1;
        check("rst_cmd_ready", cmd_ready, 32'd0);
        check("rst_rom_en", rom_en, 32'd0);
        check("rst_rom_addr", rom_addr, 32'd0);
        check("rst_write", {6'b0, write_x, write_y, write_palette}, 32'd0);
        check("rst_busy", busy, 32'd0);
        @(negedge clk_33m) rst = 1'b0;
        @(posedge clk_33m);
        #1 check("ready_after_rst", cmd_ready, 32'd1);

        // single sprite, all opaque; latency from the accepting edge
        w0 = writes_seen;
        push(10, 20, 1, 0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk_33m);
            #1 check("t1_no_write_yet", write_palette, 32'd0);
            if (i == 1) check("t1_busy", busy, 32'd1);
        end
        @(posedge clk_33m);
        #1 check("t1_first_write", {6'b0, write_x, write_y, write_palette},
                 {6'b0, 12'd10, 12'd20, 2'd3});
        wait_idle(0);
        check("t1_count", writes_seen - w0, 32'd1024);

        // flip: single opaque pixel at row 0 col 0 lands at x+31
        w0 = writes_seen;
        push(100, 50, 2, 1);
        wait_idle(0);
        check("t2_count", writes_seen - w0, 32'd1);
        check("t2_last", {6'b0, last_exp}, {6'b0, 12'd131, 12'd50, 2'd1});

        // clipping at the frame edge and on carry-out
        w0 = writes_seen;
        push(1270, 290, 3, 0);
        wait_idle(0);
        check("t3_edge_count", writes_seen - w0, 32'd100);
        w0 = writes_seen;
        push(4090, 40, 3, 0);
        wait_idle(0);
        check("t3_wrap_count", writes_seen - w0, 32'd0);

        // stall mid-sprite: everything frozen, sequence resumes intact
        w0 = writes_seen;
        push(200, 100, 1, 0);
        repeat (100) @(negedge clk_33m);
        rst_screen_33m = 1'b1;
        #1 check("t4_rom_en", rom_en, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_33m);
            #1;
            check("t4_frozen", {6'b0, write_x, write_y, write_palette}, {6'b0, last_exp});
            check("t4_rom_en_hold", rom_en, 32'd0);
        end
        @(negedge clk_33m) rst_screen_33m = 1'b0;
        wait_idle(0);
        check("t4_count", writes_seen - w0, 32'd1024);

        // nine back-to-back commands overfill the FIFO by one slot
        for (int i = 0; i < 9; i++)
            push($urandom_range(0, 1250), $urandom_range(0, 280), $urandom_range(4, 15),
                 $urandom_range(0, 1));
        check("t5_ready_low", cmd_ready, 32'd0);
        wait_idle(0);

        // random commands with random swap-window stalls
        for (int i = 0; i < 6; i++)
            push(($urandom_range(0, 3) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 1300),
                 $urandom_range(0, 330), $urandom_range(4, 15), $urandom_range(0, 1));
        wait_idle(1);

        // reset in the middle of a sprite
        push(10, 20, 1, 0);
        repeat (200) @(negedge clk_33m);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t6_rom_en", rom_en, 32'd0);
        check("t6_rom_addr", rom_addr, 32'd0);
        check("t6_write", {6'b0, write_x, write_y, write_palette}, 32'd0);
        check("t6_busy", busy, 32'd0);
        check("t6_cmd_ready", cmd_ready, 32'd0);
        repeat (3) @(negedge clk_33m);
        rst = 1'b0;
        w0 = writes_seen;
        repeat (60) @(negedge clk_33m);
        check("t6_no_writes", writes_seen - w0, 32'd0);
        check("t6_idle", busy, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
